// File: rtl/irq_controller.sv
// Multi-channel edge/level interrupt controller in front of the LEGv8 core's ExtIRQ/ExtIAck pins.
// Arbitrates masked pending requests and presents one registered request, its cause and its vector.
module irq_controller #(
    parameter int unsigned    N          = 64,
    parameter int unsigned    NCH        = 8,
    parameter logic [NCH-1:0] EDGE_MASK  = '1,
    parameter int unsigned    RR         = 0,
    parameter logic [63:0]    VEC_BASE   = 64'hD8,
    parameter logic [63:0]    VEC_STRIDE = 64'h8
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [NCH-1:0]         irq_in,
    input  logic                   mask_we,
    input  logic [NCH-1:0]         mask_wdata,
    input  logic                   ExtIAck,
    output logic                   ExtIRQ,
    output logic [$clog2(NCH)-1:0] cause,
    output logic [N-1:0]           vector,
    output logic [NCH-1:0]         pending
);

    localparam int unsigned CW = $clog2(NCH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [NCH-1:0]   sync1_q, s_q, s_dly_q;
    logic [NCH-1:0]   pending_q, pending_d;
    logic [NCH-1:0]   mask_q;
    logic [NCH-1:0]   elig, clr_vec;
    logic [CW-1:0]    last_q, last_d;
    logic [CW-1:0]    cause_q, cause_d;
    logic [N-1:0]     vector_q, vector_d;
    logic             irq_q, irq_d;
    logic             ack_take;
    logic             win_vld;
    logic [CW-1:0]    win_idx;
    int unsigned      start_idx, cand;

    // Two-flop synchroniser plus one delay stage for rise detection
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            s_q     <= '0;
            s_dly_q <= '0;
        end else begin
            sync1_q <= irq_in;
            s_q     <= sync1_q;
            s_dly_q <= s_q;
        end
    end

    // Edge channels hold until acknowledged (a fresh rise beats the clear); level channels follow s
    always_comb begin
        clr_vec   = '0;
        if (ack_take) clr_vec = NCH'(1) << cause_q;
        pending_d = (EDGE_MASK & ((pending_q & ~clr_vec) | (s_q & ~s_dly_q)))
                  | (~EDGE_MASK & s_q);
    end

    assign elig = pending_q & mask_q;

    // Scan from channel 0 (fixed) or from the slot after the last acknowledged one (round-robin)
    always_comb begin
        win_vld   = 1'b0;
        win_idx   = '0;
        start_idx = '0;
        cand      = '0;
        if (RR != 0) start_idx = (32'(last_q) + 32'd1) % NCH;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = (start_idx + k) % NCH;
            if (!win_vld && elig[CW'(cand)]) begin
                win_vld = 1'b1;
                win_idx = CW'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        vector_d = vector_q;
        last_d   = last_q;
        irq_d    = 1'b0;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d  = ST_REQ;
                    cause_d  = win_idx;
                    vector_d = N'(VEC_BASE) + N'(win_idx) * N'(VEC_STRIDE);
                    irq_d    = 1'b1;
                end
            end
            ST_REQ: begin
                irq_d = 1'b1;
                if (ExtIAck) begin
                    ack_take = 1'b1;
                    last_d   = cause_q;
                    irq_d    = 1'b0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!ExtIAck) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            mask_q    <= '0;
            last_q    <= CW'(NCH - 1);
            cause_q   <= '0;
            vector_q  <= N'(VEC_BASE);
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (mask_we) mask_q <= mask_wdata;
            last_q    <= last_d;
            cause_q   <= cause_d;
            vector_q  <= vector_d;
            irq_q     <= irq_d;
        end
    end

    assign ExtIRQ  = irq_q;
    assign cause   = cause_q;
    assign vector  = vector_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: a fixed-priority instance with channel 0 level triggered,
// and an all-edge round-robin instance; grants are checked by per-instance monitors.
module tb_irq_controller;

    typedef struct packed {
        logic [2:0]  cause;
        logic [63:0] vector;
    } grant_t;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [7:0]  a_irq, a_mask_wdata, a_pending;
    logic        a_mask_we, a_ack, a_extirq;
    logic [2:0]  a_cause;
    logic [63:0] a_vector;

    logic [7:0]  b_irq, b_mask_wdata, b_pending;
    logic        b_mask_we, b_ack, b_extirq;
    logic [2:0]  b_cause;
    logic [63:0] b_vector;

    int checks = 0;
    int errors = 0;

    grant_t a_exp_q[$];
    grant_t b_exp_q[$];
    grant_t a_e, b_e;
    logic   a_prev = 1'b0;
    logic   b_prev = 1'b0;

    irq_controller #(.N(64), .NCH(8), .EDGE_MASK(8'hFE), .RR(0),
                     .VEC_BASE(64'hD8), .VEC_STRIDE(64'h8)) dut_a (
        .CLOCK_50  (clk),
        .reset     (rst_n),
        .irq_in    (a_irq),
        .mask_we   (a_mask_we),
        .mask_wdata(a_mask_wdata),
        .ExtIAck   (a_ack),
        .ExtIRQ    (a_extirq),
        .cause     (a_cause),
        .vector    (a_vector),
        .pending   (a_pending)
    );

    irq_controller #(.N(64), .NCH(8), .EDGE_MASK(8'hFF), .RR(1),
                     .VEC_BASE(64'hD8), .VEC_STRIDE(64'h8)) dut_b (
        .CLOCK_50  (clk),
        .reset     (rst_n),
        .irq_in    (b_irq),
        .mask_we   (b_mask_we),
        .mask_wdata(b_mask_wdata),
        .ExtIAck   (b_ack),
        .ExtIRQ    (b_extirq),
        .cause     (b_cause),
        .vector    (b_vector),
        .pending   (b_pending)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: every rising ExtIRQ must match the oldest expected grant
    always @(negedge clk) begin
        if (a_extirq && !a_prev) begin
            if (a_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_grant: got cause %0d expected no grant", a_cause);
            end else begin
                a_e = a_exp_q.pop_front();
                check("a_grant_cause", 64'(a_cause), 64'(a_e.cause));
                check("a_grant_vector", a_vector, a_e.vector);
            end
        end
        a_prev = a_extirq;
    end

    always @(negedge clk) begin
        if (b_extirq && !b_prev) begin
            if (b_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_grant: got cause %0d expected no grant", b_cause);
            end else begin
                b_e = b_exp_q.pop_front();
                check("b_grant_cause", 64'(b_cause), 64'(b_e.cause));
                check("b_grant_vector", b_vector, b_e.vector);
            end
        end
        b_prev = b_extirq;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_expect(input logic [2:0] c, input logic [63:0] v);
        grant_t g;
        g.cause  = c;
        g.vector = v;
        a_exp_q.push_back(g);
    endtask

    task automatic b_expect(input logic [2:0] c, input logic [63:0] v);
        grant_t g;
        g.cause  = c;
        g.vector = v;
        b_exp_q.push_back(g);
    endtask

    task automatic a_wait_irq(input string name);
        int n = 0;
        while (!a_extirq && n < 20) begin
            tick();
            n++;
        end
        check(name, 64'(a_extirq), 64'd1);
    endtask

    task automatic b_wait_irq(input string name);
        int n = 0;
        while (!b_extirq && n < 20) begin
            tick();
            n++;
        end
        check(name, 64'(b_extirq), 64'd1);
    endtask

    task automatic a_do_ack();
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        tick();
    endtask

    task automatic b_do_ack();
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        tick();
    endtask

    task automatic a_set_mask(input logic [7:0] m);
        a_mask_we    = 1'b1;
        a_mask_wdata = m;
        tick();
        a_mask_we    = 1'b0;
    endtask

    task automatic a_pulse(input logic [7:0] lines, input int cycles);
        a_irq = lines;
        repeat (cycles) tick();
        a_irq = 8'h00;
    endtask

    task automatic b_pulse(input logic [7:0] lines, input int cycles);
        b_irq = lines;
        repeat (cycles) tick();
        b_irq = 8'h00;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a_irq = '0; a_mask_we = 1'b0; a_mask_wdata = '0; a_ack = 1'b0;
        b_irq = '0; b_mask_we = 1'b0; b_mask_wdata = '0; b_ack = 1'b0;
        repeat (2) tick();
        check("rst_extirq", 64'(a_extirq), 64'd0);
        check("rst_cause", 64'(a_cause), 64'd0);
        check("rst_vector", a_vector, 64'hD8);
        check("rst_pending", 64'(a_pending), 64'd0);
        check("rst_b_extirq", 64'(b_extirq), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single edge request on channel 3 with exact latency
        a_set_mask(8'hFF);
        a_expect(3'd3, 64'hF0);
        a_irq[3] = 1'b1;
        tick(); tick(); tick();
        check("t1_no_irq_before_k3", 64'(a_extirq), 64'd0);
        a_irq[3] = 1'b0;
        tick();
        check("t1_irq_at_k3", 64'(a_extirq), 64'd1);
        check("t1_cause", 64'(a_cause), 64'd3);
        check("t1_vector", a_vector, 64'hF0);
        a_ack = 1'b1;
        tick();
        check("t1_ack_drops_irq", 64'(a_extirq), 64'd0);
        check("t1_ack_clears_pending", 64'(a_pending[3]), 64'd0);
        a_ack = 1'b0;
        repeat (6) tick();
        check("t1_no_rerequest", 64'(a_extirq), 64'd0);

        // Simultaneous rises on 5 and 2: lowest index first
        a_expect(3'd2, 64'hE8);
        a_expect(3'd5, 64'h100);
        a_pulse(8'b0010_0100, 3);
        a_wait_irq("t2_first_grant");
        check("t2_first_cause", 64'(a_cause), 64'd2);
        a_do_ack();
        a_wait_irq("t2_second_grant");
        check("t2_second_cause", 64'(a_cause), 64'd5);
        a_do_ack();
        repeat (4) tick();
        check("t2_idle_after", 64'(a_extirq), 64'd0);
        check("t2_pending_clear", 64'(a_pending), 64'd0);

        // Masked channel latches pending but does not request until unmasked
        a_set_mask(8'h00);
        a_pulse(8'b0000_0010, 3);
        repeat (4) tick();
        check("t3_masked_pending", 64'(a_pending[1]), 64'd1);
        check("t3_masked_no_irq", 64'(a_extirq), 64'd0);
        a_expect(3'd1, 64'hE0);
        a_mask_we    = 1'b1;
        a_mask_wdata = 8'h02;
        tick();
        a_mask_we    = 1'b0;
        check("t3_not_at_write_edge", 64'(a_extirq), 64'd0);
        tick();
        check("t3_irq_after_unmask", 64'(a_extirq), 64'd1);
        a_do_ack();
        a_set_mask(8'hFF);

        // Level channel 0 re-requests while its line stays high
        a_expect(3'd0, 64'hD8);
        a_expect(3'd0, 64'hD8);
        a_irq[0] = 1'b1;
        a_wait_irq("t4_level_grant");
        a_ack = 1'b1;
        tick();
        check("t4_ack_drops_irq", 64'(a_extirq), 64'd0);
        a_ack = 1'b0;
        tick();
        tick();
        check("t4_level_rerequest", 64'(a_extirq), 64'd1);
        check("t4_level_pending_kept", 64'(a_pending[0]), 64'd1);
        a_irq[0] = 1'b0;
        repeat (3) tick();
        a_do_ack();
        repeat (6) tick();
        check("t4_no_request_after_drop", 64'(a_extirq), 64'd0);
        check("t4_level_pending_gone", 64'(a_pending[0]), 64'd0);

        // New rise on channel 4 sets pending in the same cycle the ack clears it
        a_expect(3'd4, 64'hF8);
        a_expect(3'd4, 64'hF8);
        a_pulse(8'b0001_0000, 2);
        a_wait_irq("t5_first_grant");
        a_irq[4] = 1'b1;
        tick();
        tick();
        a_irq[4] = 1'b0;
        a_ack = 1'b1;
        tick();
        check("t5_set_wins", 64'(a_pending[4]), 64'd1);
        check("t5_ack_drops_irq", 64'(a_extirq), 64'd0);
        a_ack = 1'b0;
        a_wait_irq("t5_second_grant");
        a_do_ack();
        repeat (3) tick();
        check("t5_pending_clear", 64'(a_pending[4]), 64'd0);

        // Reset while requesting drops everything immediately
        a_expect(3'd3, 64'hF0);
        a_pulse(8'b0010_1000, 3);
        a_wait_irq("t6_grant");
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_async_irq_drop", 64'(a_extirq), 64'd0);
        check("t6_pending_cleared", 64'(a_pending), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        a_set_mask(8'hFF);
        repeat (6) tick();
        check("t6_no_stale_request", 64'(a_extirq), 64'd0);
        a_expect(3'd2, 64'hE8);
        a_pulse(8'b0000_0100, 3);
        a_wait_irq("t6_new_grant");
        a_do_ack();

        // Round-robin: after channel 2 is served, repeated 2+5 rises alternate 5, 2, 5, 2
        b_mask_we    = 1'b1;
        b_mask_wdata = 8'hFF;
        tick();
        b_mask_we    = 1'b0;
        b_expect(3'd2, 64'hE8);
        b_pulse(8'b0000_0100, 3);
        b_wait_irq("rr_setup_grant");
        b_do_ack();
        for (int r = 0; r < 2; r++) begin
            b_expect(3'd5, 64'h100);
            b_expect(3'd2, 64'hE8);
            b_pulse(8'b0010_0100, 3);
            b_wait_irq("rr_grant_a");
            check("rr_first_is_5", 64'(b_cause), 64'd5);
            b_do_ack();
            b_wait_irq("rr_grant_b");
            check("rr_second_is_2", 64'(b_cause), 64'd2);
            b_do_ack();
        end
        repeat (5) tick();
        check("rr_idle_after", 64'(b_extirq), 64'd0);
        check("rr_pending_clear", 64'(b_pending), 64'd0);

        check("a_queue_drained", 64'(a_exp_q.size()), 64'd0);
        check("b_queue_drained", 64'(b_exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
